// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle between the execute/memory requesters, the decode
// read addresses and the register file write port.
//   alu_* / mem_* : requester valid/ready handshake with destination and data
//   WE3/AD3/WD3   : register file write port
//   AD1/AD2       : decode read addresses, hazard1/hazard2 : stall flags
interface wb_port_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             alu_valid;
  logic             alu_ready;
  logic [4:0]       alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             mem_valid;
  logic             mem_ready;
  logic [4:0]       mem_rd;
  logic [WIDTH-1:0] mem_data;
  logic             WE3;
  logic [4:0]       AD3;
  logic [WIDTH-1:0] WD3;
  logic [4:0]       AD1;
  logic [4:0]       AD2;
  logic             hazard1;
  logic             hazard2;

  // Pipeline side: requesters and decode.
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, AD1, AD2,
    input  alu_ready, mem_ready, WE3, AD3, WD3, hazard1, hazard2
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, AD1, AD2,
    output alu_ready, mem_ready, WE3, AD3, WD3, hazard1, hazard2
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between the ALU and load write-back
// paths. Each path has a one-entry holding buffer; an oldest-first arbiter
// with round-robin tie-break drains one entry per cycle onto WE3/AD3/WD3.
// hazard1/hazard2 flag decode reads of registers with a write still pending
// (including the write being issued this cycle).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : wb_port_arbiter_if slave modport (handshakes, write port, hazards)
module wb_port_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  wb_port_arbiter_if.slave bus
);

  logic             alu_full_q, alu_full_d, alu_age_q, alu_age_d;
  logic [4:0]       alu_rd_q, alu_rd_d;
  logic [WIDTH-1:0] alu_data_q, alu_data_d;
  logic             mem_full_q, mem_full_d, mem_age_q, mem_age_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic [WIDTH-1:0] mem_data_q, mem_data_d;
  logic             prio_q, prio_d;

  logic alu_gnt, mem_gnt, tie;
  logic alu_load, mem_load;

  // Grant depends only on registered state, so ready never depends on valid.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    tie     = 1'b0;
    if (alu_full_q && mem_full_q) begin
      if (alu_age_q != mem_age_q) begin
        alu_gnt = alu_age_q;
        mem_gnt = mem_age_q;
      end else begin
        tie     = 1'b1;
        alu_gnt = ~prio_q;
        mem_gnt = prio_q;
      end
    end else begin
      alu_gnt = alu_full_q;
      mem_gnt = mem_full_q;
    end
  end

  assign bus.alu_ready = ~alu_full_q | alu_gnt;
  assign bus.mem_ready = ~mem_full_q | mem_gnt;

  // Writes to x0 are accepted but never buffered.
  assign alu_load = bus.alu_valid & bus.alu_ready & (bus.alu_rd != 5'd0);
  assign mem_load = bus.mem_valid & bus.mem_ready & (bus.mem_rd != 5'd0);

  always_comb begin
    bus.WE3 = alu_gnt | mem_gnt;
    bus.AD3 = 5'd0;
    bus.WD3 = '0;
    if (alu_gnt) begin
      bus.AD3 = alu_rd_q;
      bus.WD3 = alu_data_q;
    end else if (mem_gnt) begin
      bus.AD3 = mem_rd_q;
      bus.WD3 = mem_data_q;
    end
  end

  assign bus.hazard1 = (bus.AD1 != 5'd0) &
                       ((alu_full_q & (alu_rd_q == bus.AD1)) |
                        (mem_full_q & (mem_rd_q == bus.AD1)));
  assign bus.hazard2 = (bus.AD2 != 5'd0) &
                       ((alu_full_q & (alu_rd_q == bus.AD2)) |
                        (mem_full_q & (mem_rd_q == bus.AD2)));

  always_comb begin
    alu_full_d = alu_full_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    alu_age_d  = alu_age_q;
    mem_full_d = mem_full_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    mem_age_d  = mem_age_q;
    prio_d     = tie ? alu_gnt : prio_q;

    // A waiting entry becomes older when the other side loads behind it.
    if (alu_load) begin
      alu_full_d = 1'b1;
      alu_rd_d   = bus.alu_rd;
      alu_data_d = bus.alu_data;
      alu_age_d  = 1'b0;
    end else if (alu_gnt) begin
      alu_full_d = 1'b0;
      alu_age_d  = 1'b0;
    end else if (mem_load && alu_full_q) begin
      alu_age_d  = 1'b1;
    end

    if (mem_load) begin
      mem_full_d = 1'b1;
      mem_rd_d   = bus.mem_rd;
      mem_data_d = bus.mem_data;
      mem_age_d  = 1'b0;
    end else if (mem_gnt) begin
      mem_full_d = 1'b0;
      mem_age_d  = 1'b0;
    end else if (alu_load && mem_full_q) begin
      mem_age_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full_q <= 1'b0;
      alu_rd_q   <= 5'd0;
      alu_data_q <= '0;
      alu_age_q  <= 1'b0;
      mem_full_q <= 1'b0;
      mem_rd_q   <= 5'd0;
      mem_data_q <= '0;
      mem_age_q  <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      alu_age_q  <= alu_age_d;
      mem_full_q <= mem_full_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      mem_age_q  <= mem_age_d;
      prio_q     <= prio_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by a
// randomized run, all checked against a timestamp-based reference model.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.WIDTH(32)) bus ();

  wb_port_arbiter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Register file fed from the DUT write port (observed side).
  logic [31:0] tb_rf [32];
  always @(posedge clk) if (bus.WE3) tb_rf[bus.AD3] <= bus.WD3;

  // Reference model: each buffer remembers the cycle it was loaded on; the
  // earliest load wins, equal load cycles go to the round-robin pointer.
  bit          m_full [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_data [2];
  int          m_stamp[2];
  bit          m_prio;
  int          m_cyc;
  logic [31:0] m_rf   [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_stamp[0] < m_stamp[1]) return 0;
      if (m_stamp[1] < m_stamp[0]) return 1;
      return m_prio ? 1 : 0;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_hazard(input logic [4:0] a);
    return (a != 5'd0) && ((m_full[0] && m_rd[0] == a) || (m_full[1] && m_rd[1] == a));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) m_full[i] = 1'b0;
    m_prio = 1'b0;
  endtask

  // One clock cycle: drive, check against model, clock, advance model.
  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic [4:0] a1, input logic [4:0] a2);
    int g;
    bit acc0, acc1, tie;
    logic [4:0]  e_ad;
    logic [31:0] e_wd;
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mr; bus.mem_data = md;
    bus.AD1 = a1; bus.AD2 = a2;
    #1;
    g = m_grant();
    e_ad = 5'd0;
    e_wd = 32'd0;
    if (g >= 0) begin
      e_ad = m_rd[g];
      e_wd = m_data[g];
    end
    chk("WE3", {31'd0, bus.WE3}, {31'd0, g >= 0});
    chk("AD3", {27'd0, bus.AD3}, {27'd0, e_ad});
    chk("WD3", bus.WD3, e_wd);
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, !m_full[0] || g == 0});
    chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, !m_full[1] || g == 1});
    chk("hazard1", {31'd0, bus.hazard1}, {31'd0, m_hazard(a1)});
    chk("hazard2", {31'd0, bus.hazard2}, {31'd0, m_hazard(a2)});
    acc0 = av && (!m_full[0] || g == 0);
    acc1 = mv && (!m_full[1] || g == 1);
    tie = m_full[0] && m_full[1] && (m_stamp[0] == m_stamp[1]);
    @(posedge clk);
    if (g >= 0) begin
      m_rf[m_rd[g]] = m_data[g];
      m_full[g] = 1'b0;
      if (tie) m_prio = (g == 0);
    end
    if (acc0 && ar != 5'd0) begin
      m_full[0] = 1'b1; m_rd[0] = ar; m_data[0] = ad; m_stamp[0] = m_cyc;
    end
    if (acc1 && mr != 5'd0) begin
      m_full[1] = 1'b1; m_rd[1] = mr; m_data[1] = md; m_stamp[1] = m_cyc;
    end
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tb_rf[i] = 32'd0;
      m_rf[i]  = 32'd0;
    end
    m_reset();
    m_cyc = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.AD1 = 0; bus.AD2 = 0;

    // Reset values, with requests presented while reset is high.
    bus.alu_valid = 1; bus.alu_rd = 5'd4; bus.mem_valid = 1; bus.mem_rd = 5'd6;
    @(posedge clk);
    #2;
    chk("rst_WE3", {31'd0, bus.WE3}, 32'd0);
    chk("rst_AD3", {27'd0, bus.AD3}, 32'd0);
    chk("rst_WD3", bus.WD3, 32'd0);
    chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset with both entries full.
    step(1, 5'd9, 32'h99, 1, 5'd10, 32'hA0, 5'd9, 5'd10);
    chk("pre_rst_WE3", {31'd0, bus.WE3}, 32'd1);
    bus.alu_valid = 0; bus.mem_valid = 0;
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("async_rst_WE3", {31'd0, bus.WE3}, 32'd0);
    chk("async_rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("async_rst_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    chk("async_rst_hazard1", {31'd0, bus.hazard1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single uncontended write.
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("single_WE3", {31'd0, bus.WE3}, 32'd1);
    chk("single_AD3", {27'd0, bus.AD3}, 32'd5);
    chk("single_WD3", bus.WD3, 32'hDEADBEEF);
    chk("single_hazard1", {31'd0, bus.hazard1}, 32'd1);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("single_done_WE3", {31'd0, bus.WE3}, 32'd0);

    // Same-edge tie, prio starts at ALU.
    step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 5'd3, 5'd3);
    chk("tie_first", bus.WD3, 32'h11);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd3, 5'd0);
    chk("tie_second", bus.WD3, 32'h22);
    idle(2);
    chk("tie_x3", tb_rf[3], 32'h22);
    // prio now favours MEM on the next tie.
    step(1, 5'd8, 32'h81, 1, 5'd8, 32'h82, 5'd0, 5'd0);
    chk("tie2_first", bus.WD3, 32'h82);
    idle(2);

    // Age ordering: MEM loaded first, ALU behind it.
    step(0, 5'd0, 32'd0, 1, 5'd7, 32'hAA, 5'd7, 5'd0);
    chk("age_first", bus.WD3, 32'hAA);
    step(1, 5'd7, 32'hBB, 0, 5'd0, 32'd0, 5'd7, 5'd0);
    chk("age_second", bus.WD3, 32'hBB);
    idle(2);
    chk("age_x7", tb_rf[7], 32'hBB);

    // Write to x0 is swallowed.
    step(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("zero_WE3", {31'd0, bus.WE3}, 32'd0);
    chk("zero_hazard1", {31'd0, bus.hazard1}, 32'd0);

    // Streaming: both requesters valid every cycle.
    for (int i = 0; i < 20; i++)
      step(1, 5'((i % 31) + 1), 32'h1000 + i, 1, 5'(((i + 10) % 31) + 1), 32'h2000 + i,
           5'((i % 31) + 1), 5'(((i + 9) % 31) + 1));
    idle(3);

    // Randomized traffic with a narrow register range to force collisions.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom,
           5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)));
    idle(3);

    // Nothing lost, duplicated or reordered per register.
    for (int r = 0; r < 32; r++) chk($sformatf("rf_x%0d", r), tb_rf[r], m_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
